// File: rtl/matmul_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// matmul_sequencer_pkg
// Shared definitions for the matrix-multiply sequencer: the controller state
// encoding and the fixed memory-layout offsets of the job header and of the
// A operand matrix.
// ----------------------------------------------------------------------------
package matmul_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_SETUP,
      S_CHECK,
      S_ISSUE,
      S_WAIT_RES,
      S_WRITE,
      S_DONE
   } state_t;

   // Header words live at the bottom of memory; A follows immediately.
   localparam int HDR_M  = 0;
   localparam int HDR_N  = 1;
   localparam int HDR_P  = 2;
   localparam int A_BASE = 3;

endpackage

// File: rtl/matmul_sequencer_addr_gen.sv
// ----------------------------------------------------------------------------
// matmul_addr_gen
// Loop counters and address pointers for one C = A x B job.
//   i_load      : restart at i = j = k = 0, arow = A_BASE, bptr = i_bBase,
//                 cptr = i_cBase
//   i_stepK     : one operand pair issued (k++, bptr += P)
//   i_stepJ     : one C element written (cptr++, advance j / i)
//   i_m/i_n/i_p : matrix dimensions
//   i_bBase     : first B address, i_cBase : first C address
//   o_addrA     : arow + k, o_addrB : bptr, o_addrC : cptr
//   o_kFirst / o_kLast : current pair is first / last of a dot product
//   o_lastElem  : the current (i, j) is the final C element
// ----------------------------------------------------------------------------
module matmul_addr_gen
   import matmul_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int MAX_LEN_LOG = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_load,
   input  logic                   i_stepK,
   input  logic                   i_stepJ,
   input  logic [MAX_LEN_LOG-1:0] i_m,
   input  logic [MAX_LEN_LOG-1:0] i_n,
   input  logic [MAX_LEN_LOG-1:0] i_p,
   input  logic [ADDR_WIDTH-1:0]  i_bBase,
   input  logic [ADDR_WIDTH-1:0]  i_cBase,
   output logic [ADDR_WIDTH-1:0]  o_addrA,
   output logic [ADDR_WIDTH-1:0]  o_addrB,
   output logic [ADDR_WIDTH-1:0]  o_addrC,
   output logic                   o_kFirst,
   output logic                   o_kLast,
   output logic                   o_lastElem
);

   logic [MAX_LEN_LOG-1:0] r_i;
   logic [MAX_LEN_LOG-1:0] r_j;
   logic [MAX_LEN_LOG-1:0] r_k;
   logic [ADDR_WIDTH-1:0]  r_arow;
   logic [ADDR_WIDTH-1:0]  r_bcol;
   logic [ADDR_WIDTH-1:0]  r_bptr;
   logic [ADDR_WIDTH-1:0]  r_cptr;

   logic [ADDR_WIDTH-1:0]  w_nExt;
   logic [ADDR_WIDTH-1:0]  w_pExt;
   logic [MAX_LEN_LOG-1:0] w_mMinus1;
   logic [MAX_LEN_LOG-1:0] w_nMinus1;
   logic [MAX_LEN_LOG-1:0] w_pMinus1;

   assign w_nExt    = ADDR_WIDTH'(i_n);
   assign w_pExt    = ADDR_WIDTH'(i_p);
   assign w_mMinus1 = i_m - MAX_LEN_LOG'(1);
   assign w_nMinus1 = i_n - MAX_LEN_LOG'(1);
   assign w_pMinus1 = i_p - MAX_LEN_LOG'(1);

   assign o_addrA    = r_arow + ADDR_WIDTH'(r_k);
   assign o_addrB    = r_bptr;
   assign o_addrC    = r_cptr;
   assign o_kFirst   = (r_k == '0);
   assign o_kLast    = (r_k == w_nMinus1);
   assign o_lastElem = (r_i == w_mMinus1) && (r_j == w_pMinus1);

   // r_bcol remembers BB + j so bptr can be rewound to the top of the next
   // B column without a multiply once a dot product finishes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i    <= '0;
         r_j    <= '0;
         r_k    <= '0;
         r_arow <= '0;
         r_bcol <= '0;
         r_bptr <= '0;
         r_cptr <= '0;
      end else if (i_load) begin
         r_i    <= '0;
         r_j    <= '0;
         r_k    <= '0;
         r_arow <= ADDR_WIDTH'(A_BASE);
         r_bcol <= i_bBase;
         r_bptr <= i_bBase;
         r_cptr <= i_cBase;
      end else begin
         if (i_stepK) begin
            r_k    <= r_k + MAX_LEN_LOG'(1);
            r_bptr <= r_bptr + w_pExt;
         end
         if (i_stepJ) begin
            r_k    <= '0;
            r_cptr <= r_cptr + ADDR_WIDTH'(1);
            if (r_j == w_pMinus1) begin
               r_j    <= '0;
               r_i    <= r_i + MAX_LEN_LOG'(1);
               r_arow <= r_arow + w_nExt;
               r_bcol <= i_bBase;
               r_bptr <= i_bBase;
            end else begin
               r_j    <= r_j + MAX_LEN_LOG'(1);
               r_bcol <= r_bcol + ADDR_WIDTH'(1);
               r_bptr <= r_bcol + ADDR_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/matmul_sequencer.sv
// ----------------------------------------------------------------------------
// matmul_sequencer
// Runs one C = A x B job out of a shared dual-port memory: reads the M/N/P
// header, validates it, streams A/B operand pairs to an external MAC datapath
// and writes every C element back through port A.
//   clk, reset (active-low, async)    start / busy / done / error
//   mem_addr_a, mem_we_a, mem_data_a, mem_q_a : port A (header, A, C)
//   mem_addr_b, mem_we_b, mem_q_b             : port B (B reads only)
//   mac_valid/first/last, mac_op_a/b          : operand stream
//   mac_result, mac_result_ready              : completed dot product
// ----------------------------------------------------------------------------
module matmul_sequencer
   import matmul_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int MAX_LEN     = 100,
   parameter int MAX_LEN_LOG = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] mem_addr_a,
   output logic [ADDR_WIDTH-1:0] mem_addr_b,
   output logic                  mem_we_a,
   output logic                  mem_we_b,
   output logic [DATA_WIDTH-1:0] mem_data_a,
   input  logic [DATA_WIDTH-1:0] mem_q_a,
   input  logic [DATA_WIDTH-1:0] mem_q_b,
   output logic                  mac_valid,
   output logic                  mac_first,
   output logic                  mac_last,
   output logic [DATA_WIDTH-1:0] mac_op_a,
   output logic [DATA_WIDTH-1:0] mac_op_b,
   input  logic [DATA_WIDTH-1:0] mac_result,
   input  logic                  mac_result_ready
);

   // Wide enough for 3 + 3*(2^MAX_LEN_LOG-1)^2 so the overflow test never
   // wraps, even for header values that are later rejected.
   localparam int EXT_W = (2*MAX_LEN_LOG + 2 > ADDR_WIDTH + 1) ?
                          2*MAX_LEN_LOG + 2 : ADDR_WIDTH + 1;
   localparam logic [EXT_W:0] ADDR_SPAN = (EXT_W+1)'(1) << ADDR_WIDTH;

   state_t                 r_state;
   state_t                 w_next;
   logic [1:0]             r_hdrCnt;
   logic [MAX_LEN_LOG-1:0] r_m;
   logic [MAX_LEN_LOG-1:0] r_n;
   logic [MAX_LEN_LOG-1:0] r_p;
   logic                   r_hdrBad;
   logic [MAX_LEN_LOG:0]   r_setupCnt;
   logic [EXT_W-1:0]       r_bb;
   logic [EXT_W-1:0]       r_np;
   logic [EXT_W-1:0]       r_mp;
   logic [DATA_WIDTH-1:0]  r_result;
   logic                   r_macValid;
   logic                   r_macFirst;
   logic                   r_macLast;
   logic                   r_error;

   logic                   w_upperBad;
   logic [MAX_LEN_LOG:0]   w_setupTotal;
   logic                   w_setupLast;
   logic [EXT_W-1:0]       w_nExt;
   logic [EXT_W-1:0]       w_pExt;
   logic [EXT_W-1:0]       w_cbWide;
   logic [EXT_W:0]         w_endWide;
   logic                   w_dimBad;
   logic                   w_bad;
   logic                   w_load;
   logic                   w_stepK;
   logic                   w_stepJ;
   logic [ADDR_WIDTH-1:0]  w_addrA;
   logic [ADDR_WIDTH-1:0]  w_addrB;
   logic [ADDR_WIDTH-1:0]  w_addrC;
   logic                   w_kFirst;
   logic                   w_kLast;
   logic                   w_lastElem;

   assign w_upperBad   = |mem_q_a[DATA_WIDTH-1:MAX_LEN_LOG];
   assign w_setupTotal = {1'b0, r_m} + {1'b0, r_n};
   assign w_setupLast  = (r_setupCnt + (MAX_LEN_LOG+1)'(1)) >= w_setupTotal;
   assign w_nExt       = EXT_W'(r_n);
   assign w_pExt       = EXT_W'(r_p);
   assign w_cbWide     = r_bb + r_np;
   assign w_endWide    = {1'b0, w_cbWide} + {1'b0, r_mp};
   assign w_dimBad     = r_hdrBad ||
                         (r_m == '0) || (r_n == '0) || (r_p == '0) ||
                         (r_m > MAX_LEN_LOG'(MAX_LEN)) ||
                         (r_n > MAX_LEN_LOG'(MAX_LEN)) ||
                         (r_p > MAX_LEN_LOG'(MAX_LEN));
   assign w_bad        = w_dimBad || (w_endWide > ADDR_SPAN);

   matmul_addr_gen #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .MAX_LEN_LOG (MAX_LEN_LOG)
   ) u_addrGen (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_stepK    (w_stepK),
      .i_stepJ    (w_stepJ),
      .i_m        (r_m),
      .i_n        (r_n),
      .i_p        (r_p),
      .i_bBase    (r_bb[ADDR_WIDTH-1:0]),
      .i_cBase    (w_cbWide[ADDR_WIDTH-1:0]),
      .o_addrA    (w_addrA),
      .o_addrB    (w_addrB),
      .o_addrC    (w_addrC),
      .o_kFirst   (w_kFirst),
      .o_kLast    (w_kLast),
      .o_lastElem (w_lastElem)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_stepK = 1'b0;
      w_stepJ = 1'b0;
      case (r_state)
         S_IDLE:     if (start) w_next = S_HDR;
         S_HDR:      if (r_hdrCnt == 2'd3) w_next = S_SETUP;
         S_SETUP:    if (w_setupLast) w_next = S_CHECK;
         S_CHECK: begin
            if (w_bad) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_ISSUE;
               w_load = 1'b1;
            end
         end
         S_ISSUE: begin
            w_stepK = 1'b1;
            if (w_kLast) w_next = S_WAIT_RES;
         end
         S_WAIT_RES: if (mac_result_ready) w_next = S_WRITE;
         S_WRITE: begin
            w_stepJ = 1'b1;
            w_next  = w_lastElem ? S_DONE : S_ISSUE;
         end
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Header words arrive one cycle after their address, so M/N/P are
   // captured at hdrCnt 1..3. SETUP first does M steps building BB (and M*P
   // for the overflow test), then N steps building N*P; CB = BB + N*P.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hdrCnt   <= '0;
         r_m        <= '0;
         r_n        <= '0;
         r_p        <= '0;
         r_hdrBad   <= 1'b0;
         r_setupCnt <= '0;
         r_bb       <= '0;
         r_np       <= '0;
         r_mp       <= '0;
         r_result   <= '0;
      end else begin
         case (r_state)
            S_IDLE: r_hdrCnt <= '0;
            S_HDR: begin
               r_hdrCnt   <= r_hdrCnt + 2'd1;
               r_setupCnt <= '0;
               r_bb       <= EXT_W'(A_BASE);
               r_np       <= '0;
               r_mp       <= '0;
               case (r_hdrCnt)
                  2'd1: begin
                     r_m      <= mem_q_a[MAX_LEN_LOG-1:0];
                     r_hdrBad <= w_upperBad;
                  end
                  2'd2: begin
                     r_n      <= mem_q_a[MAX_LEN_LOG-1:0];
                     r_hdrBad <= r_hdrBad | w_upperBad;
                  end
                  2'd3: begin
                     r_p      <= mem_q_a[MAX_LEN_LOG-1:0];
                     r_hdrBad <= r_hdrBad | w_upperBad;
                  end
                  default: ;
               endcase
            end
            S_SETUP: begin
               r_setupCnt <= r_setupCnt + (MAX_LEN_LOG+1)'(1);
               if (r_setupCnt < {1'b0, r_m}) begin
                  r_bb <= r_bb + w_nExt;
                  r_mp <= r_mp + w_pExt;
               end else begin
                  r_np <= r_np + w_pExt;
               end
            end
            S_WAIT_RES: if (mac_result_ready) r_result <= mac_result;
            default: ;
         endcase
      end
   end

   // Read data returns one cycle after the address, so the pair flags are
   // delayed by one cycle to line up with mem_q_a / mem_q_b.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_macValid <= 1'b0;
         r_macFirst <= 1'b0;
         r_macLast  <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_macValid <= (r_state == S_ISSUE);
         r_macFirst <= (r_state == S_ISSUE) && w_kFirst;
         r_macLast  <= (r_state == S_ISSUE) && w_kLast;
         r_error    <= (r_state == S_CHECK) && w_bad;
      end
   end

   always_comb begin
      mem_addr_a = '0;
      mem_addr_b = '0;
      mem_we_a   = 1'b0;
      mem_data_a = '0;
      case (r_state)
         S_HDR: begin
            if (r_hdrCnt != 2'd3)
               mem_addr_a = ADDR_WIDTH'(HDR_M) + ADDR_WIDTH'(r_hdrCnt);
         end
         S_ISSUE: begin
            mem_addr_a = w_addrA;
            mem_addr_b = w_addrB;
         end
         S_WRITE: begin
            mem_we_a   = 1'b1;
            mem_addr_a = w_addrC;
            mem_data_a = r_result;
         end
         default: ;
      endcase
   end

   // error is registered out of CHECK, so it lands in the first IDLE cycle
   // together with busy falling, just as done does in DONE.
   assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done      = (r_state == S_DONE);
   assign error     = r_error;
   assign mem_we_b  = 1'b0;
   assign mac_valid = r_macValid;
   assign mac_first = r_macFirst;
   assign mac_last  = r_macLast;
   assign mac_op_a  = r_macValid ? mem_q_a : '0;
   assign mac_op_b  = r_macValid ? mem_q_b : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// ----------------------------------------------------------------------------
// tb_matmul_sequencer
// Drives matmul_sequencer against a memory model and a MAC model with
// programmable latency. Expected C values and write addresses come from a
// plain nested-loop matrix product over the operands loaded into memory.
// ----------------------------------------------------------------------------
module tb_matmul_sequencer;

   localparam int DW     = 32;
   localparam int AW     = 12;
   localparam int BUDGET = 5000;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy, done, error;
   logic [AW-1:0] mem_addr_a, mem_addr_b;
   logic          mem_we_a, mem_we_b;
   logic [DW-1:0] mem_data_a, mem_q_a, mem_q_b;
   logic          mac_valid, mac_first, mac_last;
   logic [DW-1:0] mac_op_a, mac_op_b, mac_result;
   logic          mac_result_ready;

   always #5 clk = ~clk;

   matmul_sequencer #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .MAX_LEN     (100),
      .MAX_LEN_LOG (7)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .mem_addr_a       (mem_addr_a),
      .mem_addr_b       (mem_addr_b),
      .mem_we_a         (mem_we_a),
      .mem_we_b         (mem_we_b),
      .mem_data_a       (mem_data_a),
      .mem_q_a          (mem_q_a),
      .mem_q_b          (mem_q_b),
      .mac_valid        (mac_valid),
      .mac_first        (mac_first),
      .mac_last         (mac_last),
      .mac_op_a         (mac_op_a),
      .mac_op_b         (mac_op_b),
      .mac_result       (mac_result),
      .mac_result_ready (mac_result_ready)
   );

   // Dual-port memory with one-cycle read latency and a bench load port.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rdA, rdB;
   logic          loadEn;
   logic [AW-1:0] loadAddr;
   logic [DW-1:0] loadData;
   assign mem_q_a = rdA;
   assign mem_q_b = rdB;

   always @(posedge clk) begin
      rdA <= mem[mem_addr_a];
      rdB <= mem[mem_addr_b];
      if (loadEn)        mem[loadAddr]   <= loadData;
      else if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
   end

   // MAC datapath model: accumulates pairs, returns the sum macLatency
   // cycles after the last pair. strayReady injects a spurious strobe.
   logic [DW-1:0] macAcc, macPend, macRes;
   logic          macRdy;
   logic          strayReady;
   int            macCnt;
   int            macLatency;
   assign mac_result_ready = macRdy | strayReady;
   assign mac_result       = macRes;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         macAcc  <= '0;
         macPend <= '0;
         macRes  <= '0;
         macRdy  <= 1'b0;
         macCnt  <= 0;
      end else begin
         macRdy <= 1'b0;
         if (macCnt == 1) begin
            macRdy <= 1'b1;
            macRes <= macPend;
         end
         if (macCnt > 0) macCnt <= macCnt - 1;
         if (mac_valid) begin
            macAcc <= (mac_first ? '0 : macAcc) + mac_op_a * mac_op_b;
            if (mac_last) begin
               macPend <= (mac_first ? '0 : macAcc) + mac_op_a * mac_op_b;
               macCnt  <= macLatency;
            end
         end
      end
   end

   int            nChecks = 0;
   int            nErrors = 0;
   logic [DW-1:0] refA [0:255];
   logic [DW-1:0] refB [0:255];

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nErrors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic writeWord(input int addr, input logic [DW-1:0] data);
      loadEn   = 1'b1;
      loadAddr = AW'(addr);
      loadData = data;
      @(negedge clk);
      loadEn   = 1'b0;
   endtask

   // Loads one job, starts it and watches it to completion (or aborts it
   // with a reset), then compares against the reference product.
   task automatic applyStimulus(input logic [DW-1:0] hm, input logic [DW-1:0] hn,
                                input logic [DW-1:0] hp, input bit legal,
                                input bit useRand, input bit injStart,
                                input bit injStray, input bit injReset,
                                input string name);
      int            m, n, p, cyc, tail, doneCnt, errCnt, firstLast;
      bit            seenEnd, strayDone, aborted, busyAtEnd;
      int            wrAddr[$];
      logic [DW-1:0] wrData[$];
      int            expAddr[$];
      logic [DW-1:0] expData[$];
      logic [DW-1:0] acc;
      m = int'(hm); n = int'(hn); p = int'(hp);
      writeWord(0, hm);
      writeWord(1, hn);
      writeWord(2, hp);
      if (legal) begin
         for (int x = 0; x < m*n; x++) begin
            if (useRand) refA[x] = $urandom;
            writeWord(3 + x, refA[x]);
         end
         for (int x = 0; x < n*p; x++) begin
            if (useRand) refB[x] = $urandom;
            writeWord(3 + m*n + x, refB[x]);
         end
         for (int i = 0; i < m; i++)
            for (int j = 0; j < p; j++) begin
               acc = '0;
               for (int k = 0; k < n; k++) acc += refA[i*n+k] * refB[k*p+j];
               expAddr.push_back(3 + m*n + n*p + i*p + j);
               expData.push_back(acc);
            end
      end
      cyc = 0; tail = 0; doneCnt = 0; errCnt = 0; firstLast = 0;
      seenEnd = 0; strayDone = 0; aborted = 0; busyAtEnd = 1;
      start = 1'b1;
      while (cyc < BUDGET && tail < 4) begin
         @(negedge clk);
         cyc++;
         start      = 1'b0;
         strayReady = 1'b0;
         if (mem_we_a) begin
            wrAddr.push_back(int'(mem_addr_a));
            wrData.push_back(mem_data_a);
         end
         if (done)  begin doneCnt++; busyAtEnd = busy; end
         if (error) begin errCnt++;  busyAtEnd = busy; end
         if (mac_valid && mac_first && mac_last) firstLast++;
         if (seenEnd) tail++;
         if (done || error) seenEnd = 1;
         if (injStart && cyc == 6) start = 1'b1;
         if (injStray && !strayDone && mac_valid && mac_first) begin
            strayReady = 1'b1;
            strayDone  = 1;
         end
         if (injReset && mac_valid && !mac_first) begin
            reset = 1'b0;
            #1;
            checkOutput({name, " rst busy"},   busy, 0);
            checkOutput({name, " rst flags"},  {done, error, mac_first, mac_last, mem_we_b}, 0);
            checkOutput({name, " rst we_a"},   mem_we_a, 0);
            checkOutput({name, " rst addr"},   {mem_addr_a, mem_addr_b}, 0);
            checkOutput({name, " rst data_a"}, mem_data_a, 0);
            checkOutput({name, " rst mac"},    {mac_valid, mac_op_a, mac_op_b}, 0);
            repeat (3) begin
               @(negedge clk);
               checkOutput({name, " rst hold we_a"}, mem_we_a, 0);
            end
            reset   = 1'b1;
            aborted = 1;
            break;
         end
      end
      if (!aborted) begin
         checkOutput({name, " completes"}, seenEnd, 1);
         checkOutput({name, " busy at end"}, busyAtEnd, 0);
         checkOutput({name, " busy after"}, busy, 0);
         checkOutput({name, " first&last pairs"}, firstLast, (legal && n == 1) ? m*p : 0);
         checkOutput({name, " done count"}, doneCnt, legal ? 1 : 0);
         checkOutput({name, " error count"}, errCnt, legal ? 0 : 1);
         checkOutput({name, " write count"}, wrAddr.size(), expAddr.size());
         for (int w = 0; w < wrAddr.size() && w < expAddr.size(); w++) begin
            checkOutput($sformatf("%s wr%0d addr", name, w), wrAddr[w], expAddr[w]);
            checkOutput($sformatf("%s wr%0d data", name, w), wrData[w], expData[w]);
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; loadEn = 1'b0; loadAddr = '0; loadData = '0;
      strayReady = 1'b0; macLatency = 3;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset busy/done/error", {busy, done, error}, 0);
      checkOutput("reset mem ctl", {mem_we_a, mem_we_b, mem_addr_a, mem_addr_b}, 0);
      checkOutput("reset mac", {mac_valid, mac_first, mac_last}, 0);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] 2x2x2 directed job");
      refA[0] = 1; refA[1] = 2; refA[2] = 3; refA[3] = 4;
      refB[0] = 5; refB[1] = 6; refB[2] = 7; refB[3] = 8;
      applyStimulus(2, 2, 2, 1, 0, 0, 0, 0, "j222");
      checkOutput("j222 mem C11", mem[11], 19);
      checkOutput("j222 mem C14", mem[14], 50);

      $display("[TB] 1x1x1 job");
      refA[0] = 6; refB[0] = 7;
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, "j111");
      checkOutput("j111 mem C5", mem[5], 42);

      $display("[TB] illegal headers");
      applyStimulus(2, 0, 2, 0, 0, 0, 0, 0, "n0");
      applyStimulus(101, 2, 2, 0, 0, 0, 0, 0, "m101");
      applyStimulus(2, 2, 200, 0, 0, 0, 0, 0, "p200");
      applyStimulus(100, 100, 100, 0, 0, 0, 0, 0, "ovf100");
      applyStimulus(32'h0001_0002, 2, 2, 0, 0, 0, 0, 0, "upperbits");

      $display("[TB] start while busy, stray result strobe");
      macLatency = $urandom_range(1, 5);
      applyStimulus(2, 2, 3, 1, 1, 1, 0, 0, "restart");
      applyStimulus(2, 3, 2, 1, 1, 0, 1, 0, "stray");

      $display("[TB] reset during ISSUE then rerun");
      applyStimulus(3, 3, 3, 1, 1, 0, 0, 1, "abort333");
      @(negedge clk);
      applyStimulus(3, 3, 3, 1, 1, 0, 0, 0, "rerun333");

      $display("[TB] random jobs");
      for (int r = 0; r < 6; r++) begin
         macLatency = $urandom_range(1, 5);
         applyStimulus($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                       1, 1, 0, 0, 0, $sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that runs one complete C = A x B job out of the shared dual-port memory.
- Reads the matrix-dimension header, generates every A/B operand read address, streams operand pairs to the external multiply-accumulate datapath, and writes each C element back.
- Sits between the top-level matrix multiplier, the memory block and the multiplier block. It is the only master of both memory ports while busy.

Parameters:
- DATA_WIDTH, 32, memory word and operand width.
- ADDR_WIDTH, 12, memory address width.
- MAX_LEN, 100, largest legal value of any matrix dimension.
- MAX_LEN_LOG, 7, width of the dimension and loop counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done or error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on an illegal header.
- mem_addr_a  out  ADDR_WIDTH  port A address (A reads, header reads, C writes).
- mem_addr_b  out  ADDR_WIDTH  port B address (B reads).
- mem_we_a  out  1  port A write enable.
- mem_we_b  out  1  port B write enable; tied 0.
- mem_data_a  out  DATA_WIDTH  port A write data (C element).
- mem_q_a  in  DATA_WIDTH  port A read data; valid 1 cycle after the address.
- mem_q_b  in  DATA_WIDTH  port B read data; valid 1 cycle after the address.
- mac_valid  out  1  operand pair valid.
- mac_first  out  1  first pair of a dot product; datapath clears its accumulator.
- mac_last  out  1  last pair of a dot product.
- mac_op_a, mac_op_b  out  DATA_WIDTH  operands, wired from mem_q_a / mem_q_b.
- mac_result  in  DATA_WIDTH  completed dot product.
- mac_result_ready  in  1  one-cycle strobe qualifying mac_result; arbitrary latency after mac_last.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset asserted mid-job aborts immediately; no further memory writes occur.
- Memory layout:
  - addr 0 = M, addr 1 = N, addr 2 = P.
  - A (MxN, row-major) starts at 3.
  - B (NxP, row-major) starts at BB = 3 + M*N.
  - C (MxP, row-major) starts at CB = BB + N*P.
- States: IDLE -> HDR -> SETUP -> CHECK -> ISSUE -> WAIT_RES -> WRITE -> (ISSUE | DONE) -> IDLE.
- HDR:
  - Drive addresses 0, 1, 2 on port A in three consecutive cycles.
  - Capture M, N, P one cycle later each, truncated to MAX_LEN_LOG bits; upper bits must be 0, else the value is illegal.
- SETUP: compute BB and CB by repeated addition (M adds of N, then N adds of P); no multipliers. Takes M+N cycles.
- CHECK:
  - Any dimension equal to 0, greater than MAX_LEN, or with upper bits set, or CB + M*P > 2^ADDR_WIDTH: pulse error, go to IDLE with no write.
  - Otherwise go to ISSUE with i = j = k = 0.
- ISSUE:
  - Each cycle issue mem_addr_a = arow + k and mem_addr_b = bptr. Then k++ and bptr += P.
  - arow = 3 + i*N and bptr = BB + j at k = 0, both maintained incrementally.
  - The pair appears on mac_* exactly one cycle later with mac_valid = 1, mac_first = (k == 0), mac_last = (k == N-1).
  - Throughput is 1 pair per cycle. N pairs cover cycles t+1 .. t+N.
- WAIT_RES: hold until mac_result_ready.
- WRITE:
  - One cycle: mem_we_a = 1, mem_addr_a = cptr, mem_data_a = mac_result (registered). Then cptr++.
  - Advance j, wrapping to 0 with i++. After the final element go to DONE.
- DONE: pulse done, then IDLE. busy drops in the same cycle as the done/error pulse.
- Boundary rules:
  - start while busy is ignored.
  - A mac_result_ready outside WAIT_RES is ignored.
  - A 1x1x1 job is legal: mac_first and mac_last are asserted on the same pair.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; CHECK guarantees no wrap occurs in a legal job.

Decomposition:
- Shared package: state encoding, header offsets (HDR_M = 0, HDR_N = 1, HDR_P = 2, A_BASE = 3).
- One sub-module, matmul_addr_gen: holds the i/j/k counters plus the arow, bptr and cptr pointers, with step/wrap outputs. The FSM stays in matmul_sequencer.

Test Plan:
- M=N=P=2, A=[1 2;3 4], B=[5 6;7 8], mac model with 3-cycle latency -> C at addr 11..14 = 19, 22, 43, 50; exactly 4 writes; done once.
- M=N=P=1, A=6, B=7 -> one pair with mac_first = mac_last = 1; C at addr 5 = 42.
- N=0 -> error pulse 1 cycle; no mem_we_a; busy low afterward; no done.
- M=101 -> error; same for P=200. M=N=P=100 with ADDR_WIDTH=12 -> error (address overflow).
- start re-asserted mid-job -> ignored; only one done. Stray mac_result_ready during ISSUE -> no write.
- reset low during ISSUE of a 3x3x3 job -> all outputs 0 asynchronously. A following start completes correctly with 9 C writes.
